// File: rtl/masked_subtractor_serial.sv
// masked_subtractor_serial: bit-serial masked A-B over Boolean shares, one bit per 2-cycle step using HPC2 AND gadgets.

module hpc2_and #(
    parameter int d = 2,
    localparam int NR = d * (d - 1) / 2
) (
    input  logic          clk,
    input  logic [d-1:0]  a,
    input  logic [d-1:0]  b,
    input  logic [NR-1:0] r,
    output logic [d-1:0]  c
);
    logic [d-1:0] ab;
    logic [d*d-1:0] t;
    always_ff @(posedge clk) ab <= a & b;
    for (genvar i = 0; i < d; i++) begin : g_i
        for (genvar j = 0; j < d; j++) begin : g_j
            if (i == j) begin : g_diag
                assign t[i*d+j] = 1'b0;
            end else begin : g_off
                // r_ij and r_ji share one random bit; pair (L,H) maps onto a packed triangle
                localparam int L = i < j ? i : j;
                localparam int H = i < j ? j : i;
                localparam int K = L * d - L * (L + 1) / 2 + H - L - 1;
                logic u, v;
                always_ff @(posedge clk) begin
                    u <= ~a[i] & r[K];
                    v <= b[j] ^ r[K];
                end
                assign t[i*d+j] = u ^ (a[i] & v);
            end
        end
        assign c[i] = ab[i] ^ (^t[i*d +: d]);
    end
endmodule

module masked_subtractor_serial #(
    parameter int d = 2,
    parameter int W = 8,
    localparam int NRND = d * (d - 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W*d-1:0]  in_a,
    input  logic [W*d-1:0]  in_b,
    input  logic [NRND-1:0] rnd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W*d-1:0]  out_diff,
    output logic [d-1:0]    out_borrow
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int IW = $clog2(W + 1);
    localparam logic [d-1:0] NEG = d'(1);
    state_t state, state_n;
    logic [W*d-1:0] a_q, b_q, diff_q;
    logic [d-1:0] br_q, ai, bi, ca, cb;
    logic [IW-1:0] idx;
    logic ph, last;
    assign ai = a_q[idx*d +: d];
    assign bi = b_q[idx*d +: d];
    assign last = idx == IW'(W - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign out_diff = diff_q;
    assign out_borrow = br_q;
    // borrow = (~a & b) ^ (~(a^b) & br); the two terms are disjoint, so XOR acts as OR
    hpc2_and #(.d(d)) u_ga (.clk(clk), .a(ai ^ NEG), .b(bi), .r(rnd[NRND/2-1:0]), .c(ca));
    hpc2_and #(.d(d)) u_gb (.clk(clk), .a(ai ^ bi ^ NEG), .b(br_q), .r(rnd[NRND-1:NRND/2]), .c(cb));
    always_comb begin
        state_n = state == IDLE ? (in_valid ? CALC : IDLE) :
                  state == CALC ? (ph && last ? DONE : CALC) :
                  (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            ph <= 1'b0;
            br_q <= '0;
            diff_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            state <= state_n;
            if (in_ready && in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
                br_q <= '0;
                idx <= '0;
                ph <= 1'b0;
            end else if (state == CALC) begin
                ph <= ~ph;
                if (ph) begin
                    br_q <= ca ^ cb;
                    diff_q[idx*d +: d] <= ai ^ bi ^ br_q;
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_masked_subtractor_serial.sv
// tb_masked_subtractor_serial: directed checks of the masked serial subtractor (W=8,d=2 and W=1,d=3).

module tb_masked_subtractor_serial;
    logic clk, rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_diff;
    logic [1:0] rnd, out_borrow;
    logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [2:0] s_in_a, s_in_b, s_out_diff, s_out_borrow;
    logic [5:0] s_rnd;
    int checks = 0;
    int failures = 0;

    masked_subtractor_serial #(.d(2), .W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .rnd(rnd), .out_valid(out_valid),
        .out_ready(out_ready), .out_diff(out_diff), .out_borrow(out_borrow)
    );

    masked_subtractor_serial #(.d(3), .W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .rnd(s_rnd), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_diff(s_out_diff), .out_borrow(s_out_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fresh randomness every cycle, changed away from the active edge
    always @(negedge clk) begin
        rnd = 2'($urandom);
        s_rnd = 6'($urandom);
    end

    function automatic logic [15:0] mask8(input logic [7:0] v);
        logic [15:0] s;
        logic r;
        for (int i = 0; i < 8; i++) begin
            r = 1'($urandom);
            s[2*i] = v[i] ^ r;
            s[2*i+1] = r;
        end
        return s;
    endfunction

    function automatic logic [7:0] unmask8(input logic [15:0] s);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = s[2*i] ^ s[2*i+1];
        return v;
    endfunction

    function automatic logic [2:0] mask3(input logic v);
        logic [1:0] r;
        r = 2'($urandom);
        return {v ^ r[0] ^ r[1], r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_a = mask8(a);
        in_b = mask8(b);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic eb, input string tag, output logic [15:0] sh);
        int n;
        start8(a, b);
        wait8(n);
        chk({tag, "_latency"}, 32'(n), 16);
        chk({tag, "_diff"}, 32'(unmask8(out_diff)), 32'(ed));
        chk({tag, "_borrow"}, 32'(^out_borrow), 32'(eb));
        sh = out_diff;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ret_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_ret_out_valid"}, 32'(out_valid), 0);
    endtask

    task automatic op1(input logic a, input logic b);
        int n;
        string tag;
        tag = $sformatf("w1_a%0d_b%0d", a, b);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(s_in_ready), 1);
        s_in_a = mask3(a);
        s_in_b = mask3(b);
        s_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(n), 2);
        chk({tag, "_diff"}, 32'(^s_out_diff), 32'(a ^ b));
        chk({tag, "_borrow"}, 32'(^s_out_borrow), 32'(~a & b));
        s_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] sh, sh0, d0;
        logic [1:0] b0;
        int n, ndiff;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
        s_in_a = '0;
        s_in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_diff", 32'(out_diff), 0);
        chk("rst_out_borrow", 32'(out_borrow), 0);
        rst = 1'b0;

        op8(8'h35, 8'h12, 8'h23, 1'b0, "a35_b12", sh);
        op8(8'h00, 8'h01, 8'hFF, 1'b1, "a00_b01", sh);
        op8(8'h80, 8'h80, 8'h00, 1'b0, "a80_b80", sh);

        // backpressure with a competing request held during DONE
        start8(8'h10, 8'h20);
        wait8(n);
        chk("bp_latency", 32'(n), 16);
        in_a = mask8(8'h07);
        in_b = mask8(8'h03);
        in_valid = 1'b1;
        d0 = out_diff;
        b0 = out_borrow;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_diff_stable", 32'(out_diff), 32'(d0));
            chk("bp_borrow_stable", 32'(out_borrow), 32'(b0));
            chk("bp_in_ready_low", 32'(in_ready), 0);
            chk("bp_out_valid_high", 32'(out_valid), 1);
        end
        chk("bp_diff", 32'(unmask8(out_diff)), 32'h F0);
        chk("bp_borrow", 32'(^out_borrow), 1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_ret_in_ready", 32'(in_ready), 1);
        chk("bp_ret_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait8(n);
        chk("bp2_latency", 32'(n), 16);
        chk("bp2_diff", 32'(unmask8(out_diff)), 32'h04);
        chk("bp2_borrow", 32'(^out_borrow), 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // reset asserted during step 3
        start8(8'h55, 8'h0A);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_diff", 32'(out_diff), 0);
        chk("midrst_out_borrow", 32'(out_borrow), 0);
        op8(8'hFF, 8'h0F, 8'hF0, 1'b0, "aFF_b0F", sh);

        // same operands, fresh maskings and randomness
        op8(8'h35, 8'h12, 8'h23, 1'b0, "mask_first", sh0);
        ndiff = 0;
        for (int k = 1; k < 100; k++) begin
            op8(8'h35, 8'h12, 8'h23, 1'b0, $sformatf("mask%0d", k), sh);
            if (sh !== sh0) ndiff++;
        end
        chk("mask_shares_vary", 32'(ndiff > 0), 1);

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/masked_subtractor_serial.md
MASKED_SUBTRACTOR_SERIAL -- requirements
Module: masked_subtractor_serial

Interface
REQ-001 SHALL have parameter d, default 2: number of Boolean shares per bit.
REQ-002 SHALL have parameter W, default 8: operand width in bits; legal range is W >= 1.
REQ-003 SHALL have derived localparam NRND = d*(d-1): fresh random bits per cycle, covering two HPC2 AND gadgets at d*(d-1)/2 bits each.
REQ-004 SHALL have one clock, "clk", with all state on its rising edge; reset "rst" is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: operands present.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-009 SHALL have port in_a, input, W*d bits: minuend; bit i shares at [i*d +: d].
REQ-010 SHALL have port in_b, input, W*d bits: subtrahend, same layout as in_a.
REQ-011 SHALL have port rnd, input, NRND bits: fresh randomness, sampled every cycle.
REQ-012 SHALL have port out_valid, output, 1 bit: result present.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-014 SHALL have port out_diff, output, W*d bits: shares of (A-B) mod 2^W, same layout as in_a.
REQ-015 SHALL have port out_borrow, output, d bits: shares of borrow-out (1 iff A<B unsigned).

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 SHALL assert in_ready only in IDLE.
REQ-018 SHALL assert out_valid only in DONE.
REQ-019 SHALL, on in_valid&in_ready, latch in_a/in_b into share registers, clear the borrow shares to 0, set bit index to 0 and enter CALC.
REQ-020 SHALL, in CALC, process one bit per 2-cycle step, LSB first.
REQ-021 SHALL, in step i, compute diff_i = a_i ^ b_i ^ br_i share-wise with no gadget.
REQ-022 SHALL, in step i, compute br_(i+1) = (~a_i & b_i) ^ (~(a_i^b_i) & br_i) using two HPC2 AND gadgets launched on the first step cycle; negation applies to share 0 only.
REQ-023 SHALL keep a_i, b_i and br_i operand shares stable across both cycles of a step.
REQ-024 SHALL store the gadget result into the borrow register at the end of the second step cycle.
REQ-025 SHALL use mutually exclusive AND terms in REQ-022 so that XOR-combination equals OR.
REQ-026 SHALL take rnd for gadget A from rnd[NRND/2-1:0] and for gadget B from rnd[NRND-1:NRND/2].
REQ-027 SHALL consume rnd in every CALC cycle; no random value is reused across cycles by design.
REQ-028 SHALL, after step W-1, enter DONE with out_diff holding all W diff shares and out_borrow holding br_W.
REQ-029 SHALL give latency: accept in cycle t, out_valid high from cycle t+2W+1.
REQ-030 SHALL, in DONE, hold out_diff/out_borrow stable until out_valid&out_ready, then return to IDLE.
REQ-031 SHALL keep in_ready low in the return cycle; back-to-back throughput is one operation per 2W+2 cycles minimum.
REQ-032 SHALL ignore in_valid outside IDLE; in_a/in_b changes after acceptance do not affect the result.
REQ-033 SHALL, for W=1, perform a single step and produce borrow = ~a0 & b0.
REQ-034 SHALL never combine shares of one bit in any combinational path; unmasked values never appear on any net.

Reset
REQ-035 SHALL, on rst high at a clock edge, enter IDLE and set in_ready=1, out_valid=0, out_diff=0, out_borrow=0, bit index 0, borrow shares 0.
REQ-036 SHALL let reset dominate all handshakes.
REQ-037 SHALL make reset during CALC or DONE abort the operation with no out_valid produced for it.
REQ-038 SHALL accept a new operand only when in_valid is seen in IDLE with rst low, starting in the cycle after reset release.

Verification (W=8, d=2, random share splits, random rnd each cycle; values are unmasked XOR of shares)
REQ-039 SHALL cover A=0x35, B=0x12: diff 0x23, borrow 0, out_valid exactly 17 cycles after accept.
REQ-040 SHALL cover A=0x00, B=0x01: diff 0xFF, borrow 1; A=0x80, B=0x80: diff 0x00, borrow 0.
REQ-041 SHALL cover backpressure: out_ready held low 10 cycles in DONE gives outputs stable and in_ready 0 throughout; a new in_valid is ignored until return to IDLE.
REQ-042 SHALL cover reset mid-CALC (asserted at step 3): next cycle in_ready=1, out_valid=0; a subsequent A=0xFF, B=0x0F gives diff 0xF0, borrow 0.
REQ-043 SHALL cover the same operands under 100 different maskings and rnd streams: identical unmasked diff/borrow every time, and share vectors differ across runs.
REQ-044 SHALL cover a W=1 build: all four (a,b) pairs with d=3 give diff a^b and borrow ~a&b.
